bin2bcd_display_feeder: RTL

- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display interface.
- Accepts a 16-bit binary count plus a decimal-point mask on a start pulse.
- Converts the count to four packed BCD digits using iterative shift-add-3 (double dabble), one bit per clock.
- Presents the result as the display's 16-bit value and 4-bit dots inputs. These outputs stay stable between conversions, so the multiplexed display never shows intermediate data.

---
 rtl/bin2bcd_display_feeder.sv | 118 +++++++++++
 1 files changed

// File: rtl/bin2bcd_display_feeder.sv
// bin2bcd_display_feeder
// Sequential 16-bit binary to 4-digit packed BCD converter for the
// multiplexed seven-segment display. A start request latches the count and
// its decimal-point mask. The count is converted by shift-add-3 (double
// dabble), one bit per clock. The display-facing outputs (value, dots,
// overflow) are updated only once, on the final edge of a conversion, so the
// display never sees partially converted digits.
//
// Timing, counted from the edge that accepts start (edge 0):
//   edge 0      latch inputs, busy rises
//   edges 1..14 fourteen shift-add-3 iterations
//   edge 15     outputs load, done pulses, busy falls
//   edge 16     earliest next start
module bin2bcd_display_feeder #(
    parameter logic [15:0] MAX_VALUE = 16'd9999,
    parameter logic [15:0] OVF_CODE  = 16'hEEEE,
    parameter logic [3:0]  OVF_DOTS  = 4'b1111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] bin_in,
    input  logic [3:0]  dots_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] value,
    output logic [3:0]  dots,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Iteration count: 14 input bits cover every non-overflow value, since
    // 9999 < 2**14. Overflowing inputs are still run through the same
    // sequence, which keeps the latency identical. Their BCD result is
    // discarded in favour of OVF_CODE.
    localparam logic [3:0] LAST_ITER = 4'd13;

    state_t      state_reg;
    logic [13:0] shift_reg;
    logic [15:0] bcd_reg;
    logic [3:0]  cnt_reg;
    logic        ovf_reg;
    logic [3:0]  dots_lat_reg;

    // BCD accumulator after the add-3 correction, one nibble per digit
    logic [15:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            // Digits of 5 or more are corrected so that the next doubling
            // carries into the neighbouring decade.
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Conversion FSM. All outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            dots_lat_reg <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            value        <= '0;
            dots         <= '0;
            overflow     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg    <= bin_in[13:0];
                        bcd_reg      <= '0;
                        ovf_reg      <= (bin_in > MAX_VALUE);
                        dots_lat_reg <= dots_in;
                        cnt_reg      <= LAST_ITER;
                        busy         <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end

                SHIFT: begin
                    {bcd_reg, shift_reg} <= {bcd_adj[14:0], shift_reg, 1'b0};
                    cnt_reg              <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd0) begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    value     <= ovf_reg ? OVF_CODE : bcd_reg;
                    dots      <= ovf_reg ? OVF_DOTS : dots_lat_reg;
                    overflow  <= ovf_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
